// File: rtl/cache_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_arbiter_pkg
// Description : Shared constants for the cache read-channel arbiter.
//               - one-hot FSM state encodings
//               - read-type encodings
//               - requester identifiers
//               - cache-line beat count
// Revision    : 1.0 - initial release
// ============================================================================
package cache_rd_arbiter_pkg;

  // 32-bit beats per cache line; 4 x 32 = 128-bit ret_data
  localparam int LINE_BEATS = 4;
  localparam int BEAT_W     = 32;

  // One-hot FSM state encodings
  localparam int         STATE_W = 4;
  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_REQ   = 4'b0010;
  localparam logic [3:0] S_RESP  = 4'b0100;
  localparam logic [3:0] S_DONE  = 4'b1000;

  // Read type carried on *_rd_type
  localparam logic RD_TYPE_WORD = 1'b0;
  localparam logic RD_TYPE_LINE = 1'b1;

  // Requester identifiers, used for owner and last_grant
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

endpackage : cache_rd_arbiter_pkg
`default_nettype wire

// File: rtl/cache_rd_arbiter_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_arbiter_line_assembler
// Description : Collects 32-bit return beats into a LINE_BEATS x 32 buffer.
// Ports       :
//   clk, reset   - clock and synchronous active-high reset
//   clr_i        - zero the buffer and rewind the beat counter
//   wr_i         - store beat_i into the next free word
//   word_mode_i  - single-word read: only word 0 is ever filled
//   beat_i       - incoming 32-bit beat
//   line_o       - assembled line; word k sits in bits [32k+31:32k]
// Revision    : 1.0 - initial release
// ============================================================================
module cache_rd_arbiter_line_assembler
  import cache_rd_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic                       word_mode_i,
  input  logic [BEAT_W-1:0]          beat_i,
  output logic [BEAT_W*LINE_BEATS-1:0] line_o
);

  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  logic [CNT_W-1:0]  cnt_q;
  // Set once the last permitted word has been written; any further beats in
  // the same transaction are dropped instead of overwriting that word.
  logic              full_q;
  logic [BEAT_W-1:0] word_q [LINE_BEATS];

  logic              w_last_slot;

  // A word read has exactly one slot; a line read has LINE_BEATS slots with
  // the counter saturating on the final one.
  assign w_last_slot = word_mode_i || (cnt_q == CNT_W'(LINE_BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < LINE_BEATS; i++) begin
        word_q[i] <= '0;
      end
    end else if (wr_i && !full_q) begin
      word_q[cnt_q] <= beat_i;
      if (w_last_slot) begin
        full_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < LINE_BEATS; g++) begin : g_word
      assign line_o[BEAT_W*g +: BEAT_W] = word_q[g];
    end
  endgenerate

endmodule : cache_rd_arbiter_line_assembler
`default_nettype wire

// File: rtl/cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_arbiter
// Description : Shares one AXI-bridge read channel between icache and dcache.
//               Round-robin on ties, one transaction in flight, 32-bit beats
//               assembled into a 128-bit line and returned with one pulse.
// Ports       :
//   clk, reset                   - clock, synchronous active-high reset
//   ic_rd_req/type/addr          - icache request, held until ic_rd_rdy
//   ic_rd_rdy                    - icache request accepted (1-cycle pulse)
//   ic_ret_valid/ic_ret_data     - icache return (1-cycle pulse + line)
//   dc_*                         - same set for the dcache
//   axi_rd_req/type/addr         - request to the AXI bridge
//   axi_rd_rdy                   - bridge accepted the request
//   axi_ret_valid/last/data      - return beats from the bridge
// Revision    : 1.0 - initial release
// ============================================================================
module cache_rd_arbiter
  import cache_rd_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  // icache
  input  logic                         ic_rd_req,
  input  logic                         ic_rd_type,
  input  logic [ADDR_W-1:0]            ic_rd_addr,
  output logic                         ic_rd_rdy,
  output logic                         ic_ret_valid,
  output logic [BEAT_W*LINE_BEATS-1:0] ic_ret_data,
  // dcache
  input  logic                         dc_rd_req,
  input  logic                         dc_rd_type,
  input  logic [ADDR_W-1:0]            dc_rd_addr,
  output logic                         dc_rd_rdy,
  output logic                         dc_ret_valid,
  output logic [BEAT_W*LINE_BEATS-1:0] dc_ret_data,
  // AXI bridge
  output logic                         axi_rd_req,
  output logic                         axi_rd_type,
  output logic [ADDR_W-1:0]            axi_rd_addr,
  input  logic                         axi_rd_rdy,
  input  logic                         axi_ret_valid,
  input  logic                         axi_ret_last,
  input  logic [BEAT_W-1:0]            axi_ret_data
);

  localparam int LINE_W = BEAT_W * LINE_BEATS;

  logic [STATE_W-1:0] state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               type_q, type_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               w_any_req;
  logic               w_winner;
  logic               w_asm_clr;
  logic               w_asm_wr;
  logic               w_done;
  logic [LINE_W-1:0]  w_line;

  // --------------------------------------------------------------------------
  // Round-robin arbitration: on a tie the cache that was not granted last
  // wins; a lone requester always wins.
  // --------------------------------------------------------------------------
  assign w_any_req = ic_rd_req | dc_rd_req;

  always_comb begin
    w_winner = REQ_IC;
    if (ic_rd_req && dc_rd_req) begin
      w_winner = ~last_grant_q;
    end else if (dc_rd_req) begin
      w_winner = REQ_DC;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state. Requester inputs are only sampled in IDLE, so a request
  // withdrawn after grant still runs to completion.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    type_d       = type_q;
    addr_d       = addr_q;
    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          state_d      = S_REQ;
          owner_d      = w_winner;
          last_grant_d = w_winner;
          type_d       = (w_winner == REQ_DC) ? dc_rd_type : ic_rd_type;
          addr_d       = (w_winner == REQ_DC) ? dc_rd_addr : ic_rd_addr;
        end
      end
      S_REQ: begin
        if (axi_rd_rdy) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A last flag finishes the transaction even if the beat itself is
        // dropped because the buffer is already full.
        if (axi_ret_valid && axi_ret_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= REQ_IC;
      last_grant_q <= REQ_IC;
      type_q       <= RD_TYPE_WORD;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Line buffer: cleared on grant, written only while in RESP so stray beats
  // elsewhere are discarded.
  // --------------------------------------------------------------------------
  assign w_asm_clr = (state_q == S_IDLE) && w_any_req;
  assign w_asm_wr  = (state_q == S_RESP) && axi_ret_valid;

  cache_rd_arbiter_line_assembler #(
    .LINE_BEATS (LINE_BEATS)
  ) u_line_assembler (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (w_asm_clr),
    .wr_i        (w_asm_wr),
    .word_mode_i (type_q == RD_TYPE_WORD),
    .beat_i      (axi_ret_data),
    .line_o      (w_line)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign axi_rd_req  = (state_q == S_REQ);
  assign axi_rd_type = type_q;
  assign axi_rd_addr = addr_q;

  // Acceptance is forwarded combinationally to the owner only.
  assign ic_rd_rdy = axi_rd_req && axi_rd_rdy && (owner_q == REQ_IC);
  assign dc_rd_rdy = axi_rd_req && axi_rd_rdy && (owner_q == REQ_DC);

  assign w_done       = (state_q == S_DONE);
  assign ic_ret_valid = w_done && (owner_q == REQ_IC);
  assign dc_ret_valid = w_done && (owner_q == REQ_DC);
  assign ic_ret_data  = ic_ret_valid ? w_line : '0;
  assign dc_ret_data  = dc_ret_valid ? w_line : '0;

endmodule : cache_rd_arbiter
`default_nettype wire

// File: tb/tb_cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_rd_arbiter
// Description : Self-checking bench for cache_rd_arbiter. Directed scenarios
//               followed by randomized traffic against a behavioural model
//               (fair tie-break by last-served cache, line image computed
//               from the beat list).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_rd_arbiter;

  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_rd_req, ic_rd_type, ic_rd_rdy, ic_ret_valid;
  logic [31:0]  ic_rd_addr;
  logic [127:0] ic_ret_data;
  logic         dc_rd_req, dc_rd_type, dc_rd_rdy, dc_ret_valid;
  logic [31:0]  dc_rd_addr;
  logic [127:0] dc_ret_data;
  logic         axi_rd_req, axi_rd_type, axi_rd_rdy;
  logic [31:0]  axi_rd_addr;
  logic         axi_ret_valid, axi_ret_last;
  logic [31:0]  axi_ret_data;

  int           tests = 0;
  int           fails = 0;
  logic [31:0]  bt [8];   // beats the bridge will return for the next txn
  logic         m_last;   // model: cache served most recently

  always #5 clk = ~clk;

  cache_rd_arbiter #(
    .LINE_BEATS (4),
    .ADDR_W     (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ic_rd_req     (ic_rd_req),
    .ic_rd_type    (ic_rd_type),
    .ic_rd_addr    (ic_rd_addr),
    .ic_rd_rdy     (ic_rd_rdy),
    .ic_ret_valid  (ic_ret_valid),
    .ic_ret_data   (ic_ret_data),
    .dc_rd_req     (dc_rd_req),
    .dc_rd_type    (dc_rd_type),
    .dc_rd_addr    (dc_rd_addr),
    .dc_rd_rdy     (dc_rd_rdy),
    .dc_ret_valid  (dc_ret_valid),
    .dc_ret_data   (dc_ret_data),
    .axi_rd_req    (axi_rd_req),
    .axi_rd_type   (axi_rd_type),
    .axi_rd_addr   (axi_rd_addr),
    .axi_rd_rdy    (axi_rd_rdy),
    .axi_ret_valid (axi_ret_valid),
    .axi_ret_last  (axi_ret_last),
    .axi_ret_data  (axi_ret_data)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction for cache 'own'. Called with the request already
  // presented; checks grant latency, bridge request, rd_rdy pulse, and the
  // returned line against a model built from the beat list.
  task automatic serve(input logic own, input logic [31:0] addr, input logic typ,
                       input int rdy_dly, input int nbeats, input bit drop_early);
    logic [127:0] exp_line;
    int           lim;
    int           w;
    exp_line = '0;
    lim      = typ ? 4 : 1;
    for (int b = 0; b < nbeats; b++) begin
      if (b < lim) exp_line[32*b +: 32] = bt[b];
    end

    w = 0;
    tick(); #1;
    while (axi_rd_req !== 1'b1 && w < 8) begin
      w++;
      tick(); #1;
    end
    chk("req_latency", w, 0);
    chk("axi_addr", axi_rd_addr, addr);
    chk("axi_type", axi_rd_type, typ);
    if (drop_early) begin
      if (own == IC) ic_rd_req = 1'b0; else dc_rd_req = 1'b0;
    end
    for (int d = 0; d < rdy_dly; d++) begin
      chk("rdy_before_accept", {ic_rd_rdy, dc_rd_rdy}, 2'b00);
      tick(); #1;
      chk("axi_req_held", axi_rd_req, 1'b1);
    end
    axi_rd_rdy = 1'b1;
    #1;
    chk("rd_rdy_owner", {ic_rd_rdy, dc_rd_rdy}, (own == IC) ? 2'b10 : 2'b01);
    tick();
    axi_rd_rdy = 1'b0;
    if (own == IC) ic_rd_req = 1'b0; else dc_rd_req = 1'b0;
    #1;
    chk("rd_rdy_pulse", {ic_rd_rdy, dc_rd_rdy, axi_rd_req}, 3'b000);

    for (int b = 0; b < nbeats; b++) begin
      axi_ret_valid = 1'b1;
      axi_ret_data  = bt[b];
      axi_ret_last  = (b == nbeats - 1);
      #1;
      chk("ret_before_done", {ic_ret_valid, dc_ret_valid}, 2'b00);
      tick();
    end
    axi_ret_valid = 1'b0;
    axi_ret_last  = 1'b0;
    axi_ret_data  = $urandom;
    #1;
    chk("ret_valid_owner", {ic_ret_valid, dc_ret_valid}, (own == IC) ? 2'b10 : 2'b01);
    chk("ret_data_owner", (own == IC) ? ic_ret_data : dc_ret_data, exp_line);
    chk("ret_data_other", (own == IC) ? dc_ret_data : ic_ret_data, 128'h0);
    m_last = own;
    tick(); #1;
    chk("ret_valid_pulse", {ic_ret_valid, dc_ret_valid}, 2'b00);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ri, rd, ti, td, first;
    logic [31:0] ai, ad;
    int          nb;

    reset = 1'b1;
    ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
    axi_rd_rdy = 0; axi_ret_valid = 0; axi_ret_last = 0; axi_ret_data = 0;
    m_last = IC;
    repeat (3) tick();
    #1;
    chk("reset_outputs", {ic_rd_rdy, ic_ret_valid, dc_rd_rdy, dc_ret_valid,
                          axi_rd_req, axi_rd_type}, 6'b0);
    chk("reset_addr", axi_rd_addr, 32'h0);
    chk("reset_data", {ic_ret_data, dc_ret_data}, 128'h0);
    reset = 1'b0;

    // icache line read, bridge accepts after 2 cycles
    tick();
    ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h1fc0_0000;
    bt[0] = 32'h11; bt[1] = 32'h22; bt[2] = 32'h33; bt[3] = 32'h44;
    serve(IC, 32'h1fc0_0000, 1'b1, 2, 4, 0);

    // tie after the icache was last served: dcache first, icache next
    ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h100;
    dc_rd_req = 1; dc_rd_type = 1; dc_rd_addr = 32'h200;
    bt[0] = 32'ha1; bt[1] = 32'ha2; bt[2] = 32'ha3; bt[3] = 32'ha4;
    serve(DC, 32'h200, 1'b1, 0, 4, 0);
    bt[0] = 32'hb1; bt[1] = 32'hb2; bt[2] = 32'hb3; bt[3] = 32'hb4;
    serve(IC, 32'h100, 1'b1, 1, 4, 0);
    // third tie -> dcache again
    ic_rd_req = 1; dc_rd_req = 1;
    bt[0] = 32'hc1;
    serve(DC, 32'h200, 1'b1, 0, 1, 0);
    serve(IC, 32'h100, 1'b1, 0, 1, 0);

    // dcache single word
    dc_rd_req = 1; dc_rd_type = 0; dc_rd_addr = 32'hbfaf_8000;
    bt[0] = 32'hdeadbeef;
    serve(DC, 32'hbfaf_8000, 1'b0, 0, 1, 0);

    // early last on a line read
    ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h40;
    bt[0] = 32'ha; bt[1] = 32'hb;
    serve(IC, 32'h40, 1'b1, 0, 2, 0);

    // five beats on a line read, the fifth is dropped; request withdrawn early
    dc_rd_req = 1; dc_rd_type = 1; dc_rd_addr = 32'h80;
    bt[0] = 32'h1; bt[1] = 32'h2; bt[2] = 32'h3; bt[3] = 32'h4; bt[4] = 32'h5;
    serve(DC, 32'h80, 1'b1, 1, 5, 1);

    // reset during RESP after two beats
    dc_rd_req = 1; dc_rd_type = 1; dc_rd_addr = 32'h3000;
    tick(); #1;
    chk("rst_case_req", axi_rd_req, 1'b1);
    axi_rd_rdy = 1;
    tick();
    axi_rd_rdy = 0; dc_rd_req = 0;
    axi_ret_valid = 1; axi_ret_data = 32'haaaa;
    tick();
    axi_ret_data = 32'hbbbb;
    tick();
    axi_ret_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    axi_ret_valid = 1; axi_ret_data = 32'hcccc; axi_ret_last = 1;
    #1;
    chk("rst_no_ret", {ic_ret_valid, dc_ret_valid, axi_rd_req}, 3'b000);
    tick();
    axi_ret_valid = 0; axi_ret_last = 0;
    #1;
    chk("rst_stray_ignored", {ic_ret_valid, dc_ret_valid, axi_rd_req}, 3'b000);
    m_last = IC;
    // arbitration history is reset: a tie goes to the dcache again
    ic_rd_req = 1; ic_rd_type = 1; ic_rd_addr = 32'h500;
    dc_rd_req = 1; dc_rd_type = 1; dc_rd_addr = 32'h600;
    bt[0] = 32'h77;
    serve(DC, 32'h600, 1'b1, 0, 1, 0);
    bt[0] = 32'h88; bt[1] = 32'h99;
    serve(IC, 32'h500, 1'b1, 0, 2, 0);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) ri = 1'b1;
      ti = 1'($urandom_range(0, 1));
      td = 1'($urandom_range(0, 1));
      ai = $urandom;
      ad = $urandom;
      ic_rd_req = ri; ic_rd_type = ti; ic_rd_addr = ai;
      dc_rd_req = rd; dc_rd_type = td; dc_rd_addr = ad;
      first = (ri && rd) ? ~m_last : (rd ? DC : IC);
      for (int k = 0; k < 8; k++) bt[k] = $urandom;
      nb = ((first == IC) ? ti : td) ? $urandom_range(1, 5) : 1;
      serve(first, (first == IC) ? ai : ad, (first == IC) ? ti : td,
            $urandom_range(0, 3), nb, 1'($urandom_range(0, 1)));
      if (ri && rd) begin
        for (int k = 0; k < 8; k++) bt[k] = $urandom;
        nb = ((first == IC) ? td : ti) ? $urandom_range(1, 5) : 1;
        serve(~first, (first == IC) ? ad : ai, (first == IC) ? td : ti,
              $urandom_range(0, 3), nb, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cache_rd_arbiter
`default_nettype wire
